// File: rtl/alu_result_buffer_if.sv
// ----------------------------------------------------------------------------
// alu_result_buffer_if
// Purpose : bundles the ALU-side input handshake and the writeback-side output
//           handshake of alu_result_buffer.
// Signals : in_valid/in_ready, alu_result, alu_flags, br_cond   (ALU -> buffer)
//           out_valid/out_ready, out_result, out_flags,
//           out_branch_taken                                (buffer -> writeback)
// Modports: master - the environment (drives ALU inputs and out_ready)
//           slave  - the buffer itself
//
// Handshake: a transfer happens on a rising clk edge where valid and ready are
// both 1. The sender holds valid and payload stable until that edge.
// ready may be observed by the sender before it raises valid. The buffer's
// ready/valid depend only on its registered state and never on the partner's
// valid/ready in the same cycle.
// ----------------------------------------------------------------------------
interface alu_result_buffer_if #(
  parameter int WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] alu_result;
  logic [2:0]       alu_flags;        // {overflow, negative, zero}
  logic [1:0]       br_cond;          // 00 none, 01 beq, 10 bne, 11 bltz
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [2:0]       out_flags;
  logic             out_branch_taken;

  modport master (
    output in_valid, alu_result, alu_flags, br_cond, out_ready,
    input  in_ready, out_valid, out_result, out_flags, out_branch_taken
  );

  modport slave (
    input  in_valid, alu_result, alu_flags, br_cond, out_ready,
    output in_ready, out_valid, out_result, out_flags, out_branch_taken
  );
endinterface

// File: rtl/alu_result_buffer.sv
// ----------------------------------------------------------------------------
// alu_result_buffer
// Purpose : small FIFO between the ALU stage and writeback. Each entry holds
//           the ALU result, its flags and a branch decision resolved at push.
// Params  : WIDTH - result width, DEPTH - entries (power of two, >= 2)
// Ports   : clk        - rising-edge clock
//           rst_n      - asynchronous active-low reset
//           bus        - alu_result_buffer_if.slave (both handshakes)
//           flush      - drop all buffered entries on the next edge
//           trap_clear - clear the sticky overflow trap on the next edge
//           ovf_trap   - sticky overflow trap flag
// Config  : ALU_OVF_TRAP_EN - when defined, an overflowing push is not stored;
//           it sets ovf_trap and input stalls until trap_clear. When undefined
//           overflow entries are stored normally and ovf_trap is tied 0.
// ----------------------------------------------------------------------------
module alu_result_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  alu_result_buffer_if.slave     bus,
  input  logic                   flush,
  input  logic                   trap_clear,
  output logic                   ovf_trap
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] r_result [DEPTH];
  logic [2:0]       r_flags  [DEPTH];
  logic             r_taken  [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_full;
  logic w_out_valid;
  logic w_push;
  logic w_store;
  logic w_pop;
  logic w_trap;
  logic w_taken;

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_out_valid = (r_count != '0);

  // rst_n is folded in so in_ready reads 0 for the whole reset window.
  assign bus.in_ready = rst_n & ~w_full & ~w_trap;

  // flush wins over both handshakes in its cycle.
  assign w_push = bus.in_valid & bus.in_ready & ~flush;
  assign w_pop  = w_out_valid & bus.out_ready & ~flush;

  always_comb begin
    w_taken = 1'b0;
    case (bus.br_cond)
      2'b01:   w_taken = bus.alu_flags[0];
      2'b10:   w_taken = ~bus.alu_flags[0];
      2'b11:   w_taken = bus.alu_flags[1];
      default: w_taken = 1'b0;
    endcase
  end

`ifdef ALU_OVF_TRAP_EN
  logic r_trap;
  logic w_trap_set;

  // An overflowing push is consumed by the handshake but never stored.
  assign w_trap_set = w_push & bus.alu_flags[2];
  assign w_store    = w_push & ~bus.alu_flags[2];
  assign w_trap     = r_trap;
  assign ovf_trap   = r_trap;

  // Set has priority over clear; flush leaves the trap alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_trap <= 1'b0;
    end else if (w_trap_set) begin
      r_trap <= 1'b1;
    end else if (trap_clear) begin
      r_trap <= 1'b0;
    end
  end
`else
  logic w_unused_trap_clear;

  assign w_store             = w_push;
  assign w_trap              = 1'b0;
  assign ovf_trap            = 1'b0;
  assign w_unused_trap_clear = trap_clear;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_result[i] <= '0;
        r_flags[i]  <= '0;
        r_taken[i]  <= 1'b0;
      end
    end else if (flush) begin
      r_count  <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_store) begin
        r_result[r_wr_ptr] <= bus.alu_result;
        r_flags[r_wr_ptr]  <= bus.alu_flags;
        r_taken[r_wr_ptr]  <= w_taken;
        // DEPTH is a power of two, so the natural PW-bit rollover is the wrap.
        r_wr_ptr           <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_store, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Outputs are forced to zero whenever the buffer is empty.
  assign bus.out_valid        = w_out_valid;
  assign bus.out_result       = w_out_valid ? r_result[r_rd_ptr] : '0;
  assign bus.out_flags        = w_out_valid ? r_flags[r_rd_ptr]  : '0;
  assign bus.out_branch_taken = w_out_valid ? r_taken[r_rd_ptr]  : 1'b0;
endmodule

// File: tb/tb_alu_result_buffer.sv
module tb_alu_result_buffer;
  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int EW    = WIDTH + 4;

  // ---------------- clock / reset ----------------
  logic clk        = 1'b0;
  logic rst_n      = 1'b0;
  logic flush      = 1'b0;
  logic trap_clear = 1'b0;
  logic ovf_trap;

  always #5 clk = ~clk;

  alu_result_buffer_if #(.WIDTH(WIDTH)) bus ();

  alu_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus),
    .flush      (flush),
    .trap_clear (trap_clear),
    .ovf_trap   (ovf_trap)
  );

  int vectors     = 0;
  int miscompares = 0;

  // ---------------- reference model / scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic          m_trap = 1'b0;
  logic          m_ready;
  logic          m_valid;
  logic          m_set;
  logic [EW-1:0] m_head;

  function automatic logic exp_taken(input logic [1:0] b, input logic [2:0] f);
    case (b)
      2'b01:   return f[0];
      2'b10:   return ~f[0];
      2'b11:   return f[1];
      default: return 1'b0;
    endcase
  endfunction

  // Compares every cycle on the falling edge, then advances the model to what
  // the coming rising edge should produce.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_trap = 1'b0;
    end else begin
      m_ready = (exp_q.size() < DEPTH) && !m_trap;
      m_valid = (exp_q.size() > 0);
      m_head  = m_valid ? exp_q[0] : '0;
      m_set   = 1'b0;
      vectors++;
      if (bus.in_ready !== m_ready) begin
        miscompares++;
        $display("FAIL sb_in_ready t=%0t got %0b exp %0b", $time, bus.in_ready, m_ready);
      end
      vectors++;
      if (bus.out_valid !== m_valid) begin
        miscompares++;
        $display("FAIL sb_out_valid t=%0t got %0b exp %0b", $time, bus.out_valid, m_valid);
      end
      vectors++;
      if (ovf_trap !== m_trap) begin
        miscompares++;
        $display("FAIL sb_ovf_trap t=%0t got %0b exp %0b", $time, ovf_trap, m_trap);
      end
      vectors++;
      if ({bus.out_flags, bus.out_branch_taken, bus.out_result} !== m_head) begin
        miscompares++;
        $display("FAIL sb_head t=%0t got %h exp %h", $time,
                 {bus.out_flags, bus.out_branch_taken, bus.out_result}, m_head);
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (m_valid && bus.out_ready) void'(exp_q.pop_front());
        if (bus.in_valid && m_ready) begin
`ifdef ALU_OVF_TRAP_EN
          if (bus.alu_flags[2]) m_set = 1'b1;
          else
`endif
          exp_q.push_back({bus.alu_flags, exp_taken(bus.br_cond, bus.alu_flags), bus.alu_result});
        end
      end
      if (m_set) m_trap = 1'b1;
      else if (trap_clear) m_trap = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [2:0] f,
                       input logic [1:0] b, input logic ordy);
    bus.in_valid   = v;
    bus.alu_result = d;
    bus.alu_flags  = f;
    bus.br_cond    = b;
    bus.out_ready  = ordy;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid got %0b exp 0", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL rst_in_ready got %0b exp 0", bus.in_ready); end
    vectors++; if (bus.out_result !== '0) begin miscompares++; $display("FAIL rst_out_result got %h exp 0", bus.out_result); end
    vectors++; if (bus.out_flags !== 3'b000) begin miscompares++; $display("FAIL rst_out_flags got %b exp 000", bus.out_flags); end
    vectors++; if (ovf_trap !== 1'b0) begin miscompares++; $display("FAIL rst_ovf_trap got %0b exp 0", ovf_trap); end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL rst_first_ready got %0b exp 1", bus.in_ready); end
  endtask

  task automatic test_basic();
    drive(1'b1, 32'h0000_0005, 3'b001, 2'b01, 1'b0);
    tick();
    drive(1'b0, '0, 3'b000, 2'b00, 1'b0);
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL basic_valid got %0b exp 1", bus.out_valid); end
    vectors++; if (bus.out_result !== 32'h5) begin miscompares++; $display("FAIL basic_result got %h exp 5", bus.out_result); end
    vectors++; if (bus.out_branch_taken !== 1'b1) begin miscompares++; $display("FAIL basic_taken got %0b exp 1", bus.out_branch_taken); end
    drive(1'b0, '0, 3'b000, 2'b00, 1'b1);
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL basic_drain got %0b exp 0", bus.out_valid); end
    drive(1'b0, '0, 3'b000, 2'b00, 1'b0);
  endtask

  task automatic test_full();
    drive(1'b1, 32'hA, 3'b000, 2'b00, 1'b0);
    tick();
    drive(1'b1, 32'hB, 3'b000, 2'b00, 1'b0);
    tick();
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL full_ready got %0b exp 0", bus.in_ready); end
    drive(1'b1, 32'hC, 3'b000, 2'b00, 1'b0);
    tick();
    vectors++; if (bus.out_result !== 32'hA) begin miscompares++; $display("FAIL full_head got %h exp a", bus.out_result); end
    drive(1'b0, '0, 3'b000, 2'b00, 1'b1);
    tick();
    vectors++; if (bus.out_result !== 32'hB) begin miscompares++; $display("FAIL full_second got %h exp b", bus.out_result); end
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL full_empty got %0b exp 0", bus.out_valid); end
    drive(1'b0, '0, 3'b000, 2'b00, 1'b0);
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 32'h1, 3'b000, 2'b00, 1'b0);
    tick();
    vectors++; if (bus.out_result !== 32'h1) begin miscompares++; $display("FAIL b2b_first got %h exp 1", bus.out_result); end
    for (int k = 2; k <= 6; k++) begin
      drive(1'b1, WIDTH'(k), 3'b000, 2'b00, 1'b1);
      tick();
      vectors++; if (bus.out_result !== WIDTH'(k)) begin miscompares++; $display("FAIL b2b_result got %h exp %h", bus.out_result, WIDTH'(k)); end
      vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_count got ready %0b exp 1", bus.in_ready); end
    end
    drive(1'b0, '0, 3'b000, 2'b00, 1'b1);
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_drain got %0b exp 0", bus.out_valid); end
    drive(1'b0, '0, 3'b000, 2'b00, 1'b0);
  endtask

  task automatic test_branch();
    logic [2:0] f;
    for (int b = 0; b < 4; b++) begin
      for (int z = 0; z < 2; z++) begin
        f = {1'b0, 1'($urandom_range(0, 1)), 1'(z)};
        drive(1'b1, WIDTH'($urandom), f, 2'(b), 1'b1);
        tick();
        vectors++;
        if (bus.out_branch_taken !== exp_taken(2'(b), f)) begin
          miscompares++;
          $display("FAIL branch br=%0d flags=%b got %0b exp %0b", b, f, bus.out_branch_taken, exp_taken(2'(b), f));
        end
      end
    end
    drive(1'b0, '0, 3'b000, 2'b00, 1'b1);
    tick();
    drive(1'b0, '0, 3'b000, 2'b00, 1'b0);
  endtask

  task automatic test_flush();
    drive(1'b1, 32'h11, 3'b000, 2'b00, 1'b0);
    tick();
    drive(1'b1, 32'h22, 3'b000, 2'b00, 1'b0);
    tick();
    drive(1'b1, 32'h33, 3'b000, 2'b00, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, '0, 3'b000, 2'b00, 1'b0);
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got %0b exp 0", bus.out_valid); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_ready got %0b exp 1", bus.in_ready); end
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_discard got %0b exp 0", bus.out_valid); end
  endtask

  task automatic test_trap();
    drive(1'b1, 32'h8000_0000, 3'b110, 2'b00, 1'b0);
    tick();
    drive(1'b0, '0, 3'b000, 2'b00, 1'b0);
`ifdef ALU_OVF_TRAP_EN
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL trap_valid got %0b exp 0", bus.out_valid); end
    vectors++; if (ovf_trap !== 1'b1) begin miscompares++; $display("FAIL trap_set got %0b exp 1", ovf_trap); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL trap_stall got %0b exp 0", bus.in_ready); end
    trap_clear = 1'b1;
    tick();
    trap_clear = 1'b0;
    vectors++; if (ovf_trap !== 1'b0) begin miscompares++; $display("FAIL trap_clear got %0b exp 0", ovf_trap); end
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL trap_resume got %0b exp 1", bus.in_ready); end
`else
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL ovf_valid got %0b exp 1", bus.out_valid); end
    vectors++; if (bus.out_flags !== 3'b110) begin miscompares++; $display("FAIL ovf_flags got %b exp 110", bus.out_flags); end
    vectors++; if (bus.out_result !== 32'h8000_0000) begin miscompares++; $display("FAIL ovf_result got %h exp 80000000", bus.out_result); end
    vectors++; if (ovf_trap !== 1'b0) begin miscompares++; $display("FAIL ovf_trap_tied got %0b exp 0", ovf_trap); end
    drive(1'b0, '0, 3'b000, 2'b00, 1'b1);
    tick();
    drive(1'b0, '0, 3'b000, 2'b00, 1'b0);
`endif
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      drive(1'($urandom_range(0, 1)), WIDTH'($urandom), 3'($urandom_range(0, 7)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      flush      = ($urandom_range(0, 15) == 0);
      trap_clear = ($urandom_range(0, 7) == 0);
      tick();
    end
    drive(1'b0, '0, 3'b000, 2'b00, 1'b1);
    flush      = 1'b0;
    trap_clear = 1'b1;
    repeat (4) tick();
    trap_clear = 1'b0;
    drive(1'b0, '0, 3'b000, 2'b00, 1'b0);
  endtask

  task automatic test_async_reset();
    drive(1'b1, 32'h44, 3'b000, 2'b00, 1'b0);
    tick();
    drive(1'b1, 32'h55, 3'b000, 2'b00, 1'b0);
    tick();
    drive(1'b0, '0, 3'b000, 2'b00, 1'b0);
    vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("FAIL arst_pre got %0b exp 1", bus.out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_valid got %0b exp 0", bus.out_valid); end
    vectors++; if (ovf_trap !== 1'b0) begin miscompares++; $display("FAIL arst_trap got %0b exp 0", ovf_trap); end
    vectors++; if (bus.out_result !== '0) begin miscompares++; $display("FAIL arst_result got %h exp 0", bus.out_result); end
    vectors++; if (bus.in_ready !== 1'b0) begin miscompares++; $display("FAIL arst_ready got %0b exp 0", bus.in_ready); end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    vectors++; if (bus.in_ready !== 1'b1) begin miscompares++; $display("FAIL arst_release got %0b exp 1", bus.in_ready); end
    tick();
    vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("FAIL arst_no_partial got %0b exp 0", bus.out_valid); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    drive(1'b0, '0, 3'b000, 2'b00, 1'b0);
    test_reset();
    test_basic();
    test_full();
    test_back_to_back();
    test_branch();
    test_flush();
    test_trap();
    test_random();
    test_async_reset();
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
